// File: rtl/byte_to_word_packer_pkg.sv
// Shared constants and helpers for the byte-to-word packer.
//   BYTE_W      : width of one input byte lane
//   DEF_NBYTES  : default number of bytes per output word
//   DEF_CNT_W   : default width of the valid-byte count
//   cnt_width   : width needed to hold a count of 0..nbytes
//   lane_index  : maps a fill position to a byte lane, honouring the byte order
package packer_pkg;

    localparam int BYTE_W     = 8;
    localparam int DEF_NBYTES = 4;
    localparam int DEF_CNT_W  = $clog2(DEF_NBYTES + 1);

    function automatic int cnt_width(input int nbytes);
        return $clog2(nbytes + 1);
    endfunction

    // The first byte goes to lane 0 when LSB-first, otherwise to the top lane.
    function automatic int lane_index(input int idx, input int nbytes, input bit lsb_first);
        if (lsb_first) begin
            return idx;
        end else begin
            return nbytes - 1 - idx;
        end
    endfunction

endpackage

// File: rtl/byte_to_word_packer_if.sv
// Byte-in / word-out handshake bundle of the packer.
//   in_valid, in_byte, in_last, in_ready : byte-wide source handshake
//   out_valid, out_ready, out_word, out_cnt : word-wide sink handshake
// Modports:
//   master : the environment (byte source and word consumer)
//   slave  : the packer itself
interface byte_to_word_packer_if
    import packer_pkg::*;
#(
    parameter int NBYTES = DEF_NBYTES
);

    localparam int WORD_W = BYTE_W * NBYTES;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    logic              in_valid;
    logic [BYTE_W-1:0] in_byte;
    logic              in_last;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;
    logic [CNT_W-1:0]  out_cnt;

    modport master (
        output in_valid, in_byte, in_last, out_ready,
        input  in_ready, out_valid, out_word, out_cnt
    );

    modport slave (
        input  in_valid, in_byte, in_last, out_ready,
        output in_ready, out_valid, out_word, out_cnt
    );

endinterface

// File: rtl/byte_to_word_packer.sv
// Packs a byte stream into NBYTES-wide words with a registered valid/ready
// output. A byte flagged in_last closes the word early; the unfilled lanes
// read zero and out_cnt reports how many bytes are valid.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, discards partial and held words
//   bus   : slave side of byte_to_word_packer_if (byte in, word out)
module byte_to_word_packer
    import packer_pkg::*;
#(
    parameter int NBYTES    = DEF_NBYTES,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    byte_to_word_packer_if.slave  bus
);

    localparam int WORD_W = BYTE_W * NBYTES;
    localparam int CNT_W  = cnt_width(NBYTES);
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NBYTES - 1);

    // COLLECT: assembling; PENDING: a complete word waits for the output slot.
    typedef enum logic {
        COLLECT = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WORD_W-1:0] asm_word_r;
    logic [WORD_W-1:0] asm_word_nxt_s;
    logic [IDX_W-1:0]  idx_r;
    logic [CNT_W-1:0]  asm_cnt_r;
    logic              out_valid_r;
    logic [WORD_W-1:0] out_word_r;
    logic [CNT_W-1:0]  out_cnt_r;

    logic              full_s;
    logic              out_free_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              close_s;
    logic              move_s;
    logic [IDX_W-1:0]  lane_s;

    assign full_s     = (state_r == PENDING);
    assign out_free_s = !out_valid_r || bus.out_ready;
    // A pending word only blocks input while it cannot leave this cycle.
    assign in_ready_s = !full_s || out_free_s;
    assign accept_s   = bus.in_valid && in_ready_s;
    assign close_s    = accept_s && ((idx_r == IDX_MAX) || bus.in_last);
    assign move_s     = full_s && out_free_s;
    assign lane_s     = IDX_W'(lane_index(int'(idx_r), NBYTES, LSB_FIRST));

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_word  = out_word_r;
    assign bus.out_cnt   = out_cnt_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= COLLECT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: stay PENDING when a new word closes in the same cycle the old one leaves.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            COLLECT: begin
                if (close_s) begin
                    state_nxt_s = PENDING;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            PENDING: begin
                if (move_s && !close_s) begin
                    state_nxt_s = COLLECT;
                end else begin
                    state_nxt_s = PENDING;
                end
            end
            default: begin
                state_nxt_s = COLLECT;
            end
        endcase
    end

    // Next assembly word: cleared on move, then the accepted byte lands in its lane.
    always_comb begin
        asm_word_nxt_s = asm_word_r;
        if (move_s) begin
            asm_word_nxt_s = {WORD_W{1'b0}};
        end else begin
            asm_word_nxt_s = asm_word_r;
        end
        if (accept_s) begin
            asm_word_nxt_s[lane_s*BYTE_W +: BYTE_W] = bus.in_byte;
        end else begin
            asm_word_nxt_s[lane_s*BYTE_W +: BYTE_W] = asm_word_nxt_s[lane_s*BYTE_W +: BYTE_W];
        end
    end

    // Assembly register, fill index and held byte count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_word_r <= {WORD_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            asm_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            asm_word_r <= asm_word_nxt_s;
            if (accept_s) begin
                if (close_s) begin
                    idx_r     <= {IDX_W{1'b0}};
                    asm_cnt_r <= CNT_W'(idx_r) + CNT_W'(1);
                end else begin
                    idx_r <= idx_r + IDX_W'(1);
                end
            end
        end
    end

    // Output slot: load on move, otherwise drop valid/count once the word is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_word_r  <= {WORD_W{1'b0}};
            out_cnt_r   <= {CNT_W{1'b0}};
        end else if (move_s) begin
            out_valid_r <= 1'b1;
            out_word_r  <= asm_word_r;
            out_cnt_r   <= asm_cnt_r;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            out_cnt_r   <= {CNT_W{1'b0}};
        end
    end

endmodule
